// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared state encoding and operation-select constants for serial_addsub
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SUB_ADD = 1'b0;
  localparam logic SUB_SUB = 1'b1;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - one-bit full-adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial add/subtract, LSB first, one full-adder cell
// SERIAL_ADDSUB_OVF_EN adds a signed-overflow output ovf.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fulladder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is a + ~b + 1: invert b here, the +1 enters as the initial carry.
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub == SUB_SUB}};
          carry_d = (sub == SUB_SUB);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result = res_q;
  assign cout   = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       sub_s;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .sub       (sub_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand set for one cycle, then waits (bounded) for out_valid.
  // lat counts cycles after the accept cycle until out_valid is seen; result is left held.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       output int lat, output bit timeout);
    @(negedge clk);
    a_s = av; b_s = bv; sub_s = sv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a_s = ~av; b_s = ~bv; sub_s = ~sv;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    timeout = !out_valid;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 8'h00)   begin errors++; $display("FAIL reset_result got %h exp 00", result); end
    checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat; bit to;
    do_op(8'h5A, 8'h33, 1'b0, lat, to);
    checks++; if (to)              begin errors++; $display("FAIL add1_timeout got no out_valid exp out_valid"); end
    checks++; if (lat !== 9)       begin errors++; $display("FAIL add1_latency got %0d exp 9", lat); end
    checks++; if (result !== 8'h8D) begin errors++; $display("FAIL add1_result got %h exp 8d", result); end
    checks++; if (cout !== 1'b0)   begin errors++; $display("FAIL add1_cout got %b exp 0", cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b1)    begin errors++; $display("FAIL add1_ovf got %b exp 1", ovf); end
`endif
    retire();
    do_op(8'hFF, 8'h01, 1'b0, lat, to);
    checks++; if (to)              begin errors++; $display("FAIL add2_timeout got no out_valid exp out_valid"); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL add2_result got %h exp 00", result); end
    checks++; if (cout !== 1'b1)   begin errors++; $display("FAIL add2_cout got %b exp 1", cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL add2_ovf got %b exp 0", ovf); end
`endif
    retire();
  endtask

  task automatic test_sub();
    logic [7:0] va [3] = '{8'h10, 8'h20, 8'h00};
    logic [7:0] vb [3] = '{8'h20, 8'h10, 8'h00};
    logic [7:0] er [3] = '{8'hF0, 8'h10, 8'h00};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b1, lat, to);
      checks++; if (to)                begin errors++; $display("FAIL sub%0d_timeout got no out_valid exp out_valid", i); end
      checks++; if (result !== er[i])  begin errors++; $display("FAIL sub%0d_result got %h exp %h", i, result, er[i]); end
      checks++; if (cout !== ec[i])    begin errors++; $display("FAIL sub%0d_cout got %b exp %b", i, cout, ec[i]); end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    do_op(8'h20, 8'h10, 1'b1, lat, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got no out_valid exp out_valid"); end
    for (int i = 0; i < 5; i++) begin
      a_s = 8'(i * 37); b_s = 8'(~(i * 11)); in_valid = 1'b1; sub_s = i[0];
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, in_ready); end
      checks++; if (result !== 8'h10)   begin errors++; $display("FAIL bp_result cyc %0d got %h exp 10", i, result); end
      checks++; if (cout !== 1'b1)      begin errors++; $display("FAIL bp_cout cyc %0d got %b exp 1", i, cout); end
    end
    in_valid = 1'b0;
    retire();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_after_ready got %b exp 1", in_ready); end
    repeat (12) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_handshake got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_abort();
    int lat; bit to;
    @(negedge clk);
    a_s = 8'h55; b_s = 8'h22; sub_s = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b exp 0", out_valid); end
    repeat (10) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result got %b exp 0", out_valid); end
    do_op(8'h01, 8'h01, 1'b0, lat, to);
    checks++; if (to)               begin errors++; $display("FAIL abort_next_timeout got no out_valid exp out_valid"); end
    checks++; if (lat !== 9)        begin errors++; $display("FAIL abort_next_latency got %0d exp 9", lat); end
    checks++; if (result !== 8'h02) begin errors++; $display("FAIL abort_next_result got %h exp 02", result); end
    checks++; if (cout !== 1'b0)    begin errors++; $display("FAIL abort_next_cout got %b exp 0", cout); end
    retire();
  endtask

  task automatic test_overflow();
    int lat; bit to;
    do_op(8'h7F, 8'h01, 1'b0, lat, to);
    checks++; if (to)               begin errors++; $display("FAIL ovf_timeout got no out_valid exp out_valid"); end
    checks++; if (result !== 8'h80) begin errors++; $display("FAIL ovf_result got %h exp 80", result); end
    checks++; if (cout !== 1'b0)    begin errors++; $display("FAIL ovf_cout got %b exp 0", cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b1)     begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
`endif
    retire();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_s = 8'h00; b_s = 8'h00; sub_s = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_abort();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
